// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the RISC-16 multi-cycle core. It holds the PC and the IR, and runs
// a req/ack read handshake to instruction memory. Stale returns after a redirect are discarded.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              jmp,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_VALID
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt, pc_redir;
  logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
  logic [15:0]       instr_nxt;
  logic              ir_valid_nxt;
  logic              discard, discard_nxt;
  logic              redirect;

  assign redirect = jmp | pc_en;

  // jmp has priority over pc_en; the increment wraps naturally at the address width.
  assign pc_redir = jmp ? instr[ADDR_W-1:0] : pc + 1'b1;

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = redirect ? pc_redir : pc;
    fetch_addr_nxt = fetch_addr;
    instr_nxt      = instr;
    ir_valid_nxt   = ir_valid;
    discard_nxt    = discard;

    case (state)
      F_IDLE: begin
        state_nxt      = F_REQ;
        fetch_addr_nxt = pc_nxt;
      end
      F_REQ: begin
        if (imem_ack) begin
          // The return is stale if the PC moved during the fetch, or moves on this very cycle.
          if (discard || redirect) begin
            discard_nxt    = 1'b0;
            fetch_addr_nxt = pc_nxt;
          end else begin
            instr_nxt    = imem_rdata;
            ir_valid_nxt = 1'b1;
            state_nxt    = F_VALID;
          end
        end else if (redirect) begin
          discard_nxt = 1'b1;
        end
      end
      F_VALID: begin
        if (redirect) begin
          ir_valid_nxt   = 1'b0;
          fetch_addr_nxt = pc_nxt;
          state_nxt      = F_REQ;
        end
      end
      default: state_nxt = F_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= F_IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      instr      <= 16'h0000;
      ir_valid   <= 1'b0;
      discard    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetch_addr <= fetch_addr_nxt;
      instr      <= instr_nxt;
      ir_valid   <= ir_valid_nxt;
      discard    <= discard_nxt;
    end
  end

  assign imem_req  = (state == F_REQ);
  assign imem_addr = fetch_addr;
  assign opcode    = instr[15:12];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed boundary scenarios, then randomized redirects against a
// random-latency memory, scored by a queue of expected (pc, instruction) pairs.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic        jmp;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        ir_valid;
  logic [7:0]  pc;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .pc_en     (pc_en),
    .jmp       (jmp),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ack  (imem_ack),
    .instr     (instr),
    .opcode    (opcode),
    .ir_valid  (ir_valid),
    .pc        (pc)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem[256];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mem_en = 0;
  bit          mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: answers each request after 0..3 wait cycles with the word at imem_addr.
  initial begin
    int unsigned wait_cnt;
    wait_cnt = $urandom_range(0, 3);
    forever begin
      @(negedge clk);
      if (mem_en) begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        if (imem_req) begin
          if (wait_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
            wait_cnt   = $urandom_range(0, 3);
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Monitor: scores each new valid instruction, and checks IR and fetch-address stability.
  initial begin
    logic        prev_valid = 1'b0;
    logic [15:0] prev_instr = 16'h0;
    logic [7:0]  prev_addr  = 8'h0;
    logic        hold       = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (ir_valid && !prev_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected_valid: got instr %0h at pc %0h, expected no instruction", instr, pc);
          end else begin
            e = sb.pop_front();
            check("sb_instr", instr, e.instr);
            check("sb_opcode", opcode, e.instr[15:12]);
            check("sb_pc", pc, e.pc);
          end
        end else begin
          check("ir_hold", instr, prev_instr);
        end
        if (hold && imem_req) check("addr_stable", imem_addr, prev_addr);
      end
      prev_valid = ir_valid;
      prev_instr = instr;
      prev_addr  = imem_addr;
      hold       = imem_req && !imem_ack;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  pc_model;
    logic [15:0] ir_model;
    int          kind;
    int          n_redir;
    rst_n      = 1'b0;
    pc_en      = 1'b0;
    jmp        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    // Reset values, then zero-wait fetch of address 0.
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instr, 16'h0000);
    check("rst_opcode", opcode, 4'h0);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_req", imem_req, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_req", imem_req, 1'b1);
    check("t1_addr", imem_addr, 8'h00);
    imem_ack = 1'b1; imem_rdata = 16'hC123;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t1_instr", instr, 16'hC123);
    check("t1_opcode", opcode, 4'hC);
    check("t1_valid", ir_valid, 1'b1);
    check("t1_req_low", imem_req, 1'b0);

    // Increment, then a 3-wait-cycle fetch.
    pc_en = 1'b1;
    @(negedge clk);
    pc_en = 1'b0;
    check("t2_pc", pc, 8'h01);
    check("t2_valid_fall", ir_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t2_req", imem_req, 1'b1);
      check("t2_addr_stable", imem_addr, 8'h01);
      if (i == 3) begin
        imem_ack = 1'b1; imem_rdata = 16'h20FF;
      end else begin
        check("t2_no_valid", ir_valid, 1'b0);
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    check("t2_valid", ir_valid, 1'b1);
    check("t2_instr", instr, 16'h20FF);

    // Jump to 0xFF, then wrap to 0x00.
    jmp = 1'b1;
    @(negedge clk);
    jmp = 1'b0;
    check("t3_jmp_pc", pc, 8'hFF);
    check("t3_jmp_addr", imem_addr, 8'hFF);
    imem_ack = 1'b1; imem_rdata = 16'hF042;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t3_valid", ir_valid, 1'b1);
    pc_en = 1'b1;
    @(negedge clk);
    pc_en = 1'b0;
    check("t3_wrap_pc", pc, 8'h00);
    check("t3_wrap_addr", imem_addr, 8'h00);
    check("t3_wrap_req", imem_req, 1'b1);
    imem_ack = 1'b1; imem_rdata = 16'hF042;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t3_instr", instr, 16'hF042);

    // jmp and pc_en together: jmp wins.
    jmp = 1'b1; pc_en = 1'b1;
    @(negedge clk);
    jmp = 1'b0; pc_en = 1'b0;
    check("t4_pc", pc, 8'h42);
    check("t4_addr", imem_addr, 8'h42);
    imem_ack = 1'b1; imem_rdata = 16'h0005;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t4_instr", instr, 16'h0005);

    // Two increments while the fetch of address 5 is outstanding: stale ack is dropped.
    jmp = 1'b1;
    @(negedge clk);
    jmp = 1'b0;
    check("t5_pc", pc, 8'h05);
    check("t5_addr", imem_addr, 8'h05);
    pc_en = 1'b1;
    repeat (2) @(negedge clk);
    pc_en = 1'b0;
    check("t5_pc_accum", pc, 8'h07);
    check("t5_addr_held", imem_addr, 8'h05);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t5_instr_kept", instr, 16'h0005);
    check("t5_still_invalid", ir_valid, 1'b0);
    check("t5_refetch_req", imem_req, 1'b1);
    check("t5_refetch_addr", imem_addr, 8'h07);
    imem_ack = 1'b1; imem_rdata = 16'h9009;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t5_instr", instr, 16'h9009);
    check("t5_valid", ir_valid, 1'b1);

    // Reset during an outstanding fetch of address 9, late ack after release.
    jmp = 1'b1;
    @(negedge clk);
    jmp = 1'b0;
    check("t6_pc", pc, 8'h09);
    check("t6_req", imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_pc", pc, 8'h00);
    check("t6_rst_req", imem_req, 1'b0);
    check("t6_rst_instr", instr, 16'h0000);
    check("t6_rst_addr", imem_addr, 8'h00);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t6_fresh_req", imem_req, 1'b1);
    check("t6_fresh_addr", imem_addr, 8'h00);
    check("t6_late_ack_ignored", instr, 16'h0000);
    check("t6_no_valid", ir_valid, 1'b0);

    // Randomized phase against the reference model.
    rst_n = 1'b0;
    @(negedge clk);
    pc_model = 8'h00;
    sb.push_back('{pc: pc_model, instr: mem[pc_model]});
    mem_en = 1;
    mon_en = 1;
    rst_n  = 1'b1;
    for (int t = 0; t < 200; t++) begin
      for (int c = 0; c < 64 && !ir_valid; c++) @(negedge clk);
      if (!ir_valid) begin
        check("rand_fetch_timeout", ir_valid, 1'b1);
        break;
      end
      ir_model = mem[pc_model];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n_redir = $urandom_range(1, 3);
      for (int k = 0; k < n_redir; k++) begin
        if (k > 0 && !(imem_req && !ir_valid)) break;
        kind  = $urandom_range(0, 2);
        pc_en = (kind != 1);
        jmp   = (kind != 0);
        pc_model = jmp ? ir_model[7:0] : pc_model + 8'h01;
        @(negedge clk);
        pc_en = 1'b0;
        jmp   = 1'b0;
      end
      sb.push_back('{pc: pc_model, instr: mem[pc_model]});
    end
    for (int c = 0; c < 64 && !ir_valid; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
